// File: rtl/hazard_unit_if.sv
// ID-stage hazard handshake between the pipeline (master) and hazard_unit (slave).
interface hazard_unit_if;
   logic       id_valid;
   logic [4:0] id_rs;
   logic       id_rs_use;
   logic [4:0] id_rt;
   logic       id_rt_use;
   logic [4:0] id_wr_addr;
   logic       id_wr_en;
   logic       id_is_load;
   logic       branch_taken;
   logic       pause;
   logic       hold_pc;
   logic       hold_ifid;
   logic       flush_ifid;
   logic [1:0] fwd_a;
   logic [1:0] fwd_b;

   modport master (
      output id_valid, id_rs, id_rs_use, id_rt, id_rt_use,
             id_wr_addr, id_wr_en, id_is_load, branch_taken,
      input  pause, hold_pc, hold_ifid, flush_ifid, fwd_a, fwd_b
   );

   modport slave (
      input  id_valid, id_rs, id_rs_use, id_rt, id_rt_use,
             id_wr_addr, id_wr_en, id_is_load, branch_taken,
      output pause, hold_pc, hold_ifid, flush_ifid, fwd_a, fwd_b
   );
endinterface

// File: rtl/hazard_unit.sv
// RAW hazard detection over an EXE/MEM/WB destination scoreboard, with pipeline hold/flush and stall counting.
// Build option HAZARD_FWD_EN: load-use-only stalls plus operand forwarding selects.
module hazard_unit #(
   parameter int CNT_W = 32
) (
   input  logic             clk,
   input  logic             rst,
   hazard_unit_if.slave     hz,
   output logic [CNT_W-1:0] stall_count
);

   typedef struct packed {
      logic [4:0] wa;
      logic       we;
      logic       ld;
   } sb_entry_t;

   sb_entry_t sb_e, sb_m, sb_w, sb_e_next;
   logic      raw_rs, raw_rt, raw, stall;
   logic      pause_int;
   logic      unused_ld;

   function automatic logic hit(input sb_entry_t ent, input logic [4:0] r);
      return (r != 5'd0) && ent.we && (ent.wa == r);
   endfunction

`ifdef HAZARD_FWD_EN
   // A load still in EXE has no result yet, so it is never forwarded; the stall covers it.
   function automatic logic [1:0] fwd_sel(input sb_entry_t e, input sb_entry_t m,
                                          input sb_entry_t w, input logic [4:0] r);
      logic [1:0] sel;
      sel = 2'd0;
      if (hit(e, r))      sel = e.ld ? 2'd0 : 2'd1;
      else if (hit(m, r)) sel = 2'd2;
      else if (hit(w, r)) sel = 2'd3;
      return sel;
   endfunction
`endif

   always_comb begin
      raw_rs = 1'b0;
      raw_rt = 1'b0;
`ifdef HAZARD_FWD_EN
      raw_rs = hz.id_rs_use && hit(sb_e, hz.id_rs) && sb_e.ld;
      raw_rt = hz.id_rt_use && hit(sb_e, hz.id_rt) && sb_e.ld;
`else
      raw_rs = hz.id_rs_use &&
               (hit(sb_e, hz.id_rs) || hit(sb_m, hz.id_rs) || hit(sb_w, hz.id_rs));
      raw_rt = hz.id_rt_use &&
               (hit(sb_e, hz.id_rt) || hit(sb_m, hz.id_rt) || hit(sb_w, hz.id_rt));
`endif
      raw   = hz.id_valid && (raw_rs || raw_rt);
      stall = raw && !hz.branch_taken && !rst;
   end

   always_comb begin
      pause_int     = 1'b0;
      hz.hold_pc    = 1'b0;
      hz.hold_ifid  = 1'b0;
      hz.flush_ifid = 1'b0;
      if (rst) begin
         pause_int = 1'b1;
      end else if (hz.branch_taken) begin
         pause_int     = 1'b1;
         hz.flush_ifid = 1'b1;
      end else if (stall) begin
         pause_int    = 1'b1;
         hz.hold_pc   = 1'b1;
         hz.hold_ifid = 1'b1;
      end
      hz.pause = pause_int;
   end

   always_comb begin
      hz.fwd_a = 2'd0;
      hz.fwd_b = 2'd0;
`ifdef HAZARD_FWD_EN
      if (!rst) begin
         hz.fwd_a = fwd_sel(sb_e, sb_m, sb_w, hz.id_rs);
         hz.fwd_b = fwd_sel(sb_e, sb_m, sb_w, hz.id_rt);
      end
`endif
   end

   always_comb begin
      sb_e_next = '0;
      if (!pause_int && hz.id_valid) begin
         sb_e_next.wa = hz.id_wr_addr;
         sb_e_next.we = hz.id_wr_en && (hz.id_wr_addr != 5'd0);
         sb_e_next.ld = hz.id_is_load;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         sb_e        <= '0;
         sb_m        <= '0;
         sb_w        <= '0;
         stall_count <= '0;
      end else begin
         sb_w <= sb_m;
         sb_m <= sb_e;
         sb_e <= sb_e_next;
         if (stall && (stall_count != {CNT_W{1'b1}}))
            stall_count <= stall_count + 1'b1;
      end
   end

   // Load flags in M/W are carried for visibility only.
   assign unused_ld = ^{sb_e.ld, sb_m.ld, sb_w.ld};

endmodule

// File: tb/tb_hazard_unit.sv
// Directed vector bench for hazard_unit; a second 2-bit-counter instance shares the stimulus to cover saturation.
module tb_hazard_unit;
   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] cnt_main;
   logic [1:0]  cnt_sat;
   int          n_cmp = 0;
   int          n_bad = 0;

   hazard_unit_if bus0 ();
   hazard_unit_if bus1 ();

   hazard_unit #(.CNT_W(32)) dut (.clk(clk), .rst(rst), .hz(bus0.slave), .stall_count(cnt_main));
   hazard_unit #(.CNT_W(2))  dut_sat (.clk(clk), .rst(rst), .hz(bus1.slave), .stall_count(cnt_sat));

   always #5 clk = ~clk;

   typedef struct {
      logic       rst;
      logic       vld;
      logic [4:0] rs;
      logic       rsu;
      logic [4:0] rt;
      logic       rtu;
      logic [4:0] wa;
      logic       we;
      logic       ld;
      logic       br;
      logic       p;
      logic       hpc;
      logic       hif;
      logic       fl;
      logic [1:0] fa;
      logic [1:0] fb;
      int         cnt;
   } vec_t;

   vec_t vecs[$];

`ifdef HAZARD_FWD_EN
   localparam int STALLS_PER_USE = 1;
`else
   localparam int STALLS_PER_USE = 3;
`endif

   task automatic chk(input string name, input int idx, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_bad++;
         $display("FAIL %s step %0d: got %0d expected %0d", name, idx, act, exp);
      end
   endtask

   task automatic drive(input vec_t v);
      rst                = v.rst;
      bus0.id_valid      = v.vld;  bus1.id_valid     = v.vld;
      bus0.id_rs         = v.rs;   bus1.id_rs        = v.rs;
      bus0.id_rs_use     = v.rsu;  bus1.id_rs_use    = v.rsu;
      bus0.id_rt         = v.rt;   bus1.id_rt        = v.rt;
      bus0.id_rt_use     = v.rtu;  bus1.id_rt_use    = v.rtu;
      bus0.id_wr_addr    = v.wa;   bus1.id_wr_addr   = v.wa;
      bus0.id_wr_en      = v.we;   bus1.id_wr_en     = v.we;
      bus0.id_is_load    = v.ld;   bus1.id_is_load   = v.ld;
      bus0.branch_taken  = v.br;   bus1.branch_taken = v.br;
   endtask

   task automatic step(input vec_t v, input int idx);
      int exp_sat;
      drive(v);
      @(negedge clk);
      exp_sat = (v.cnt > 3) ? 3 : v.cnt;
      chk("pause",      idx, int'(bus0.pause),      int'(v.p));
      chk("hold_pc",    idx, int'(bus0.hold_pc),    int'(v.hpc));
      chk("hold_ifid",  idx, int'(bus0.hold_ifid),  int'(v.hif));
      chk("flush_ifid", idx, int'(bus0.flush_ifid), int'(v.fl));
      chk("fwd_a",      idx, int'(bus0.fwd_a),      int'(v.fa));
      chk("fwd_b",      idx, int'(bus0.fwd_b),      int'(v.fb));
      chk("stall_count",     idx, int'(cnt_main), v.cnt);
      chk("stall_count_sat", idx, int'(cnt_sat),  exp_sat);
      @(posedge clk);
      #1;
   endtask

   initial begin
      vec_t v;
      int   total;
      // rst vld rs rsu rt rtu wa we ld br | p hpc hif fl fa fb cnt
`ifdef HAZARD_FWD_EN
      vecs.push_back('{1,1, 5,1, 0,0,  0,0,0,0, 1,0,0,0,0,0,0});
      vecs.push_back('{0,1, 5,1, 0,0,  4,1,1,0, 0,0,0,0,0,0,0});
      vecs.push_back('{0,1, 4,1, 4,1,  6,1,0,0, 1,1,1,0,0,0,0});
      vecs.push_back('{0,1, 4,1, 4,1,  6,1,0,0, 0,0,0,0,2,2,1});
      vecs.push_back('{0,1, 6,1, 4,1,  0,0,0,0, 0,0,0,0,1,3,1});
      vecs.push_back('{0,1, 6,1, 0,0,  0,1,0,0, 0,0,0,0,2,0,1});
      vecs.push_back('{0,1, 0,1, 0,1,  0,0,0,0, 0,0,0,0,0,0,1});
      vecs.push_back('{0,1, 1,1, 2,1,  9,1,1,0, 0,0,0,0,0,0,1});
      vecs.push_back('{0,1, 0,0, 9,1,  0,0,0,1, 1,0,0,1,0,0,1});
      vecs.push_back('{0,0, 9,1, 9,1,  0,0,0,0, 0,0,0,0,2,2,1});
      vecs.push_back('{0,1, 0,0, 0,0, 12,1,1,0, 0,0,0,0,0,0,1});
      vecs.push_back('{0,1,12,1, 0,0,  0,0,0,0, 1,1,1,0,0,0,1});
      vecs.push_back('{1,1,12,1, 0,0,  0,0,0,0, 1,0,0,0,0,0,2});
      vecs.push_back('{0,1,12,1, 0,0,  0,0,0,0, 0,0,0,0,0,0,0});
`else
      vecs.push_back('{1,1, 5,1, 0,0,  0,0,0,0, 1,0,0,0,0,0,0});
      vecs.push_back('{0,1, 5,1, 0,0,  3,1,0,0, 0,0,0,0,0,0,0});
      vecs.push_back('{0,1, 3,1, 0,0,  7,1,0,0, 1,1,1,0,0,0,0});
      vecs.push_back('{0,1, 3,1, 0,0,  7,1,0,0, 1,1,1,0,0,0,1});
      vecs.push_back('{0,1, 3,1, 0,0,  7,1,0,0, 1,1,1,0,0,0,2});
      vecs.push_back('{0,1, 3,1, 0,0,  7,1,0,0, 0,0,0,0,0,0,3});
      vecs.push_back('{0,0, 7,1, 0,0,  0,0,0,0, 0,0,0,0,0,0,3});
      vecs.push_back('{0,1, 8,1, 0,0,  0,1,0,0, 0,0,0,0,0,0,3});
      vecs.push_back('{0,1, 0,1, 0,1,  0,0,0,0, 0,0,0,0,0,0,3});
      vecs.push_back('{0,1, 0,0, 0,0, 10,1,0,0, 0,0,0,0,0,0,3});
      vecs.push_back('{0,1,10,0,10,1,  0,0,0,1, 1,0,0,1,0,0,3});
      vecs.push_back('{0,1,10,0,10,1,  0,0,0,0, 1,1,1,0,0,0,3});
      vecs.push_back('{0,1,10,0,10,1,  0,0,0,0, 1,1,1,0,0,0,4});
      vecs.push_back('{0,1,10,0,11,1, 12,1,0,0, 0,0,0,0,0,0,5});
      vecs.push_back('{0,1,12,1, 0,0,  0,0,0,0, 1,1,1,0,0,0,5});
      vecs.push_back('{1,1,12,1, 0,0,  0,0,0,0, 1,0,0,0,0,0,6});
      vecs.push_back('{0,1,12,1, 0,0,  0,0,0,0, 0,0,0,0,0,0,0});
      vecs.push_back('{0,0, 0,0, 0,0,  0,0,0,1, 1,0,0,1,0,0,0});
      vecs.push_back('{0,0, 0,0, 0,0,  0,0,0,0, 0,0,0,0,0,0,0});
`endif

      v = '{1,0,0,0,0,0,0,0,0,0, 1,0,0,0,0,0,0};
      drive(v);
      repeat (2) @(posedge clk);
      #1;

      for (int i = 0; i < vecs.size(); i++) step(vecs[i], i);

      // Back-to-back lw $20 / consumer pairs drive the 2-bit counter past all-ones.
      total = 0;
      for (int k = 0; k < 4; k++) begin
         v = '{0,1, 0,0, 0,0, 20,1,1,0, 0,0,0,0,0,0,total};
         step(v, 100 + k * 10);
         for (int s = 0; s < STALLS_PER_USE; s++) begin
            v = '{0,1,20,1, 0,0, 0,0,0,0, 1,1,1,0,0,0,total + s};
            step(v, 101 + k * 10 + s);
         end
         total += STALLS_PER_USE;
`ifdef HAZARD_FWD_EN
         v = '{0,1,20,1, 0,0, 0,0,0,0, 0,0,0,0,2,0,total};
`else
         v = '{0,1,20,1, 0,0, 0,0,0,0, 0,0,0,0,0,0,total};
`endif
         step(v, 105 + k * 10);
      end
      v = '{0,0, 0,0, 0,0, 0,0,0,0, 0,0,0,0,0,0,total};
      step(v, 200);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
